// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer in front of a UART transmitter.
// Ports: clk, rst_n | wr_data, wr_en, full, empty, level, overflow | tx_data, tx_send, tx_busy.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              push;
  logic              pop;
  state_t            state_q;
  state_t            state_d;

  // full is the previous edge's flag, so a same-edge pop never admits a write
  assign push = wr_en & ~full;
  assign pop  = (state_q == IDLE) & ~empty & ~tx_busy;

  assign level_nxt = level
                   + {{ADDR_W{1'b0}}, push}
                   - {{ADDR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_en && full) overflow <= 1'b1;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == FULL_LVL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (pop)     state_d = LAUNCH;
      LAUNCH:                 state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // send is high exactly while the FSM sits in LAUNCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= 8'h00;
      tx_send <= 1'b0;
    end else begin
      tx_send <= (state_d == LAUNCH);
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random and directed stimulus against a queue-based model.
// A simple transmitter model drives tx_busy and checks the launched byte stream.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TICK  = 4;
  localparam int FRAME = 10 * TICK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_busy;
  logic          force_busy = 1'b0;
  int            xcnt = 0;
  int            nsent = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign tx_busy = (xcnt != 0) | force_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: contents as a queue, launch availability as rules.
  logic [7:0] m_q[$];
  logic [7:0] exp_out[$];
  bit         m_ovf  = 1'b0;
  bit         m_send = 1'b0;
  bit         m_infl = 1'b0;
  bit         m_seen = 1'b0;
  int         m_n    = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_po;
  bit         m_pu;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_out.delete();
      m_ovf  = 1'b0;
      m_send = 1'b0;
      m_infl = 1'b0;
      m_seen = 1'b0;
      m_n    = 0;
      m_data = 8'h00;
    end else begin
      m_po = !m_infl && (m_q.size() > 0) && !tx_busy;
      m_pu = wr_en && (m_q.size() < DEPTH);
      if (wr_en && !m_pu) m_ovf = 1'b1;
      // after a launch: skip the send cycle, see busy rise, then see it low
      if (m_infl) begin
        m_n++;
        if (m_n >= 2) begin
          if (!m_seen) begin
            if (tx_busy) m_seen = 1'b1;
          end else if (!tx_busy) begin
            m_infl = 1'b0;
          end
        end
      end
      if (m_po) begin
        m_data = m_q.pop_front();
        exp_out.push_back(m_data);
        m_infl = 1'b1;
        m_seen = 1'b0;
        m_n    = 0;
      end
      if (m_pu) m_q.push_back(wr_data);
      m_send = m_po;
    end
  end

  // Transmitter model: samples send when idle, busy from next cycle for FRAME.
  always @(posedge clk) begin
    if (xcnt != 0) begin
      xcnt <= xcnt - 1;
    end else if (tx_send) begin
      xcnt <= FRAME;
      nsent <= nsent + 1;
      if (exp_out.size() == 0) begin
        chk("rx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_byte", {24'h0, tx_data}, {24'h0, exp_out.pop_front()});
      end
    end
  end

  bit prev_send = 1'b0;
  bit lvl_cap = 1'b0;

  always @(negedge clk) begin
    chk("level", 32'(level), 32'(m_q.size()));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_send", 32'(tx_send), 32'(m_send));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    if (tx_send) chk("send_gap", 32'(prev_send), 32'd0);
    if (lvl_cap) chk("level_le2", 32'(level <= 2), 32'd1);
    prev_send = tx_send;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((m_q.size() != 0 || m_infl || xcnt != 0) && t < 4000) begin
      step();
      t++;
    end
    chk("drain_timeout", 32'(t < 4000), 32'd1);
    chk("drain_left", 32'(exp_out.size()), 32'd0);
  endtask

  int base;

  initial begin
    repeat (3) step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_send", 32'(tx_send), 32'd0);
    rst_n = 1'b1;
    step();

    // single byte into empty FIFO
    base = nsent;
    wr(8'h55);
    chk("t1_lvl", 32'(level), 32'd1);
    chk("t1_nosend", 32'(tx_send), 32'd0);
    step();
    chk("t1_send", 32'(tx_send), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h55);
    chk("t1_empty", 32'(empty), 32'd1);
    step();
    chk("t1_send_lo", 32'(tx_send), 32'd0);
    drain();
    chk("t1_frames", 32'(nsent - base), 32'd1);

    // burst to full, then one dropped write
    base = nsent;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
    wr(8'hAA);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_level2", 32'(level), 32'd16);
    force_busy = 1'b0;
    drain();
    chk("t2_frames", 32'(nsent - base), 32'd16);

    // level 5, push and pop on the same edge, then wrap
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
    chk("t3_lvl5", 32'(level), 32'd5);
    force_busy = 1'b0;
    wr(8'h35);
    chk("t3_same", 32'(level), 32'd5);
    chk("t3_send", 32'(tx_send), 32'd1);
    for (int i = 0; i < 14; i++) begin
      wr(8'($urandom));
      repeat ($urandom_range(0, 30)) step();
    end
    drain();

    // foreign busy holds the sequencer
    base = nsent;
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) wr(8'hC0 + 8'(i));
    repeat (20) step();
    chk("t4_lvl", 32'(level), 32'd3);
    chk("t4_none", 32'(nsent - base), 32'd0);
    force_busy = 1'b0;
    drain();
    chk("t4_frames", 32'(nsent - base), 32'd3);

    // reset while waiting for the frame to finish
    base = nsent;
    for (int i = 0; i < 5; i++) wr(8'hE0 + 8'(i));
    repeat (10) step();
    chk("t5_lvl4", 32'(level), 32'd4);
    rst_n = 1'b0;
    step();
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_send", 32'(tx_send), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (3 * FRAME) step();
    chk("t5_frames", 32'(nsent - base), 32'd1);

    // one byte per frame time
    base = nsent;
    lvl_cap = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr(8'($urandom));
      repeat (FRAME + 4) step();
    end
    drain();
    lvl_cap = 1'b0;
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_frames", 32'(nsent - base), 32'd12);

    // random traffic with occasional foreign busy
    for (int i = 0; i < 600; i++) begin
      wr_en = ($urandom_range(0, 9) < 3);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 49) == 0) force_busy = ~force_busy;
      step();
    end
    wr_en = 1'b0;
    force_busy = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
